ipg_chan_demux: RTL

IPG_CHAN_DEMUX -- requirements
Module: ipg_chan_demux

---
 rtl/ipg_pkg.sv | 21 ++
 rtl/ipg_chan_fifo.sv | 74 +++++++
 rtl/ipg_chan_demux.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG channel demultiplexer: channel codes,
// input FSM state encoding and the drop counter width.
package ipg_pkg;

  localparam int CH_WREQ    = 0;
  localparam int CH_RREQ    = 1;
  localparam int CH_RRESP   = 2;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DROP   = 2'd2
  } in_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ipg_chan_fifo.sv
// One per-channel first-word-fall-through FIFO. Tracks occupancy and drives
// a registered pause flag with set/clear hysteresis.
module ipg_chan_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int LEN_WIDTH     = 6,
  parameter int DEPTH         = 16,
  parameter int PAUSE_THRESH  = 12,
  parameter int RESUME_THRESH = 8,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  input  logic                  wr_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_last,
  output logic [AW:0]           occupancy,
  output logic                  pause
);

  localparam int          EW         = DATA_WIDTH + LEN_WIDTH + 1;
  localparam logic [AW:0] OCC_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_PAUSE  = (AW+1)'(PAUSE_THRESH);
  localparam logic [AW:0] OCC_RESUME = (AW+1)'(RESUME_THRESH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_next;
  logic          rd_fire;
  logic          wr_fire;

  assign rd_valid  = (occ != '0);
  assign rd_fire   = rd_ready && rd_valid;
  // A write into a full FIFO is only taken when the head leaves in the same cycle.
  assign wr_fire   = wr_en && ((occ != OCC_FULL) || rd_fire);
  assign {rd_data, rd_len, rd_last} = mem[rd_ptr];
  assign occupancy = occ;

  // Storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= {wr_data, wr_len, wr_last};
  end

  // Next occupancy: a simultaneous read and write cancel out.
  always_comb begin
    occ_next = occ;
    if (wr_fire && !rd_fire)      occ_next = occ + 1'b1;
    else if (!wr_fire && rd_fire) occ_next = occ - 1'b1;
  end

  // Pointers wrap naturally at DEPTH; pause follows the new occupancy with hysteresis.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      pause  <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_next;
      if (occ_next >= OCC_PAUSE)       pause <= 1'b1;
      else if (occ_next <= OCC_RESUME) pause <= 1'b0;
    end
  end

endmodule

// File: rtl/ipg_chan_demux.sv
// Steers an unstallable stream of IPG chunks into per-channel FIFOs. A message
// is admitted only if its FIFO can take a maximum-length message, so accepted
// chunks never need back-pressure.
module ipg_chan_demux
  import ipg_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int LEN_WIDTH      = 6,
  parameter int NUM_CHAN       = 3,
  parameter int DEPTH          = 16,
  parameter int MAX_MSG_CHUNKS = 4,
  parameter int PAUSE_THRESH   = 12,
  parameter int RESUME_THRESH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [LEN_WIDTH-1:0]           in_len,
  input  logic [$clog2(NUM_CHAN)-1:0]    in_chan,
  input  logic                           in_last,
  input  logic                           in_valid,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CHAN*LEN_WIDTH-1:0]  out_len,
  output logic [NUM_CHAN-1:0]            out_last,
  output logic [NUM_CHAN-1:0]            out_valid,
  input  logic [NUM_CHAN-1:0]            out_ready,
  output logic [NUM_CHAN-1:0]            chan_pause,
  output logic [NUM_CHAN*DROP_CNT_W-1:0] drop_count,
  output logic                           chan_err
);

  localparam int             CW         = $clog2(NUM_CHAN);
  localparam int             AW         = $clog2(DEPTH);
  localparam int             CNTW       = $clog2(MAX_MSG_CHUNKS + 1);
  localparam logic [CNTW-1:0] MAX_CNT   = CNTW'(MAX_MSG_CHUNKS);
  localparam logic [AW:0]    ROOM_LIMIT = (AW+1)'(DEPTH - MAX_MSG_CHUNKS);

  in_state_t            state;
  in_state_t            state_next;
  logic [CW-1:0]        tgt_chan;
  logic [CW-1:0]        tgt_next;
  logic [CNTW-1:0]      chunk_cnt;
  logic [CNTW-1:0]      cnt_next;
  logic [NUM_CHAN-1:0]  in_onehot;
  logic [NUM_CHAN-1:0]  tgt_onehot;
  logic [NUM_CHAN-1:0]  wr_sel;
  logic [NUM_CHAN-1:0]  drop_inc;
  logic                 room_ok;
  logic                 chan_ok;
  logic                 wr_last;
  logic                 err_next;
  logic [AW:0]          occ [NUM_CHAN];

  // Decode the incoming and stored channel numbers and look up admission room.
  always_comb begin
    in_onehot  = '0;
    tgt_onehot = '0;
    room_ok    = 1'b0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (in_chan == CW'(c)) begin
        in_onehot[c] = 1'b1;
        room_ok      = (occ[c] <= ROOM_LIMIT);
      end
      if (tgt_chan == CW'(c)) tgt_onehot[c] = 1'b1;
    end
  end

  assign chan_ok = |in_onehot;

  // Input FSM next state, FIFO write selects, error and drop events.
  always_comb begin
    state_next = state;
    tgt_next   = tgt_chan;
    cnt_next   = chunk_cnt;
    wr_sel     = '0;
    wr_last    = in_last;
    err_next   = 1'b0;
    drop_inc   = '0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (!chan_ok) begin
            err_next = 1'b1;
            if (!in_last) state_next = ST_DROP;
          end else if (room_ok) begin
            wr_sel   = in_onehot;
            tgt_next = in_chan;
            cnt_next = CNTW'(1);
            wr_last  = in_last || (MAX_MSG_CHUNKS == 1);
            if (!in_last) state_next = ST_ACCEPT;
          end else begin
            drop_inc = in_onehot;
            if (!in_last) state_next = ST_DROP;
          end
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          if (chunk_cnt == MAX_CNT) begin
            err_next   = 1'b1;
            state_next = in_last ? ST_IDLE : ST_DROP;
          end else begin
            wr_sel   = tgt_onehot;
            cnt_next = chunk_cnt + 1'b1;
            wr_last  = in_last || (cnt_next == MAX_CNT);
            if (in_last) state_next = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (in_valid && in_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Input FSM registers and the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tgt_chan  <= '0;
      chunk_cnt <= '0;
      chan_err  <= 1'b0;
    end else begin
      state     <= state_next;
      tgt_chan  <= tgt_next;
      chunk_cnt <= cnt_next;
      chan_err  <= err_next;
    end
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    logic [DROP_CNT_W-1:0] drops;

    ipg_chan_fifo #(
      .DATA_WIDTH   (DATA_WIDTH),
      .LEN_WIDTH    (LEN_WIDTH),
      .DEPTH        (DEPTH),
      .PAUSE_THRESH (PAUSE_THRESH),
      .RESUME_THRESH(RESUME_THRESH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_sel[c]),
      .wr_data  (in_data),
      .wr_len   (in_len),
      .wr_last  (wr_last),
      .rd_valid (out_valid[c]),
      .rd_ready (out_ready[c]),
      .rd_data  (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rd_len   (out_len[c*LEN_WIDTH +: LEN_WIDTH]),
      .rd_last  (out_last[c]),
      .occupancy(occ[c]),
      .pause    (chan_pause[c])
    );

    // Count messages refused for lack of room on this channel, saturating.
    always_ff @(posedge clk) begin
      if (rst)              drops <= '0;
      else if (drop_inc[c]) drops <= sat_inc(drops);
    end

    assign drop_count[c*DROP_CNT_W +: DROP_CNT_W] = drops;
  end

endmodule
